// File: rtl/tl_pkg.sv
// Shared intersection/pedestrian definitions: FSM encodings, lamp masks and
// the default timing constants used by both the light and crosswalk controllers.
package tl_pkg;

  typedef enum logic [2:0] {
    PED_IDLE  = 3'd0,
    PED_REQ   = 3'd1,
    PED_WALK  = 3'd2,
    PED_FLASH = 3'd3,
    PED_HOLD  = 3'd4
  } ped_state_e;

  typedef enum logic [1:0] {
    LT_GRN = 2'd0,
    LT_YLW = 2'd1,
    LT_RED = 2'd2
  } light_state_e;

  // One-hot vehicle lamp masks {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YLW = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int DEF_TICK_DIV       = 21;
  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_WALK_TON       = 10;
  localparam int DEF_FLASH_TON      = 6;
  localparam int DEF_HOLDOFF        = 8;
  localparam int DEF_TIMER_W        = 8;
  localparam int DEF_LT_GRN_TICKS   = 30;
  localparam int DEF_LT_YLW_TICKS   = 5;

  typedef struct packed {
    ped_state_e state;
    logic       sel;
    logic       last_served;
  } ped_dbg_t;

  // Durations of zero behave as a single tick.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 2^DIV divider producing a one-clk enable pulse when the
// counter reads all-ones; used instead of a derived clock.
module tick_prescaler #(
  parameter int DIV = 21
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  logic [DIV-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_q + DIV'(1);
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/crosswalk_scheduler.sv
// Pedestrian-phase controller: debounces/latches two crosswalk buttons, requests
// the matching green and sequences WALK / flashing DON'T-WALK. CROSSWALK_AUDIO_EN adds the beep cue.
module crosswalk_scheduler
  import tl_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int WALK_TON       = DEF_WALK_TON,
  parameter int FLASH_TON      = DEF_FLASH_TON,
  parameter int HOLDOFF        = DEF_HOLDOFF,
  parameter int TIMER_W        = DEF_TIMER_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_0,
  input  logic       btn_1,
  input  logic       phase_grn_0,
  input  logic       phase_grn_1,
  output logic       req_0,
  output logic       req_1,
  output logic       walk_0,
  output logic       dontwalk_0,
  output logic       walk_1,
  output logic       dontwalk_1,
  output logic [1:0] pending,
  output logic       beep,
  output logic       tick,
  output ped_dbg_t   dbg
);

  localparam logic [TIMER_W-1:0] DB_TOP     = TIMER_W'(at_least_one(DEBOUNCE_TICKS));
  localparam logic [TIMER_W-1:0] WALK_LAST  = TIMER_W'(at_least_one(WALK_TON) - 1);
  localparam logic [TIMER_W-1:0] FLASH_LAST = TIMER_W'(at_least_one(FLASH_TON) - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(at_least_one(HOLDOFF) - 1);

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  logic [1:0]              sync1_q, sync2_q;
  logic [1:0][TIMER_W-1:0] db_q, db_d;
  logic [1:0]              press_set;
  logic [1:0]              pending_q, pending_d, clr;
  ped_state_e              state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    last_q, last_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [1:0]              grn;
  logic                    grn_sel;

  assign grn     = {phase_grn_1, phase_grn_0};
  assign grn_sel = grn[sel_q];

  // Debounce counters saturate at DB_TOP so a held button only latches once.
  always_comb begin
    db_d      = db_q;
    press_set = '0;
    for (int i = 0; i < 2; i++) begin
      if (!sync2_q[i]) begin
        db_d[i] = '0;
      end else if (tick && db_q[i] != DB_TOP) begin
        db_d[i] = db_q[i] + TIMER_W'(1);
        if (db_d[i] == DB_TOP) press_set[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    timer_d = timer_q;
    clr     = '0;
    case (state_q)
      PED_IDLE: begin
        if (pending_q != 2'b00) begin
          state_d = PED_REQ;
          if (pending_q == 2'b01)      sel_d = 1'b0;
          else if (pending_q == 2'b10) sel_d = 1'b1;
          else if (grn == 2'b01)       sel_d = 1'b0;
          else if (grn == 2'b10)       sel_d = 1'b1;
          else                         sel_d = ~last_q;
        end
      end
      PED_REQ: begin
        if (grn_sel) begin
          timer_d    = '0;
          clr[sel_q] = 1'b1;
          last_d     = sel_q;
          state_d    = PED_WALK;
        end
      end
      PED_WALK: begin
        if (!grn_sel) begin
          timer_d = '0;
          state_d = PED_FLASH;
        end else if (tick) begin
          if (timer_q == WALK_LAST) begin
            timer_d = '0;
            state_d = PED_FLASH;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      PED_FLASH: begin
        if (tick) begin
          if (timer_q == FLASH_LAST) begin
            timer_d = '0;
            state_d = PED_HOLD;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      PED_HOLD: begin
        if (tick) begin
          if (timer_q == HOLD_LAST) begin
            timer_d = '0;
            state_d = PED_IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = PED_HOLD;
      end
    endcase
  end

  // A press completing on the very clk its road is granted is a new request and wins.
  assign pending_d = (pending_q & ~clr) | press_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      pending_q <= '0;
      state_q   <= PED_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      timer_q   <= '0;
    end else begin
      sync1_q   <= {btn_1, btn_0};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
    end
  end

  logic [1:0] req_v, walk_v, dw_v;

  // The flash timer counts ticks from 0, so its LSB is the flashing lamp phase.
  always_comb begin
    req_v  = 2'b00;
    walk_v = 2'b00;
    dw_v   = 2'b11;
    case (state_q)
      PED_REQ: req_v[sel_q] = 1'b1;
      PED_WALK: begin
        req_v[sel_q]  = 1'b1;
        walk_v[sel_q] = 1'b1;
        dw_v[sel_q]   = 1'b0;
      end
      PED_FLASH: dw_v[sel_q] = timer_q[0];
      default: ;
    endcase
  end

  assign {req_1, req_0}           = req_v;
  assign {walk_1, walk_0}         = walk_v;
  assign {dontwalk_1, dontwalk_0} = dw_v;
  assign pending                  = pending_q;

`ifdef CROSSWALK_AUDIO_EN
  logic beep_q, beep_d;

  always_comb begin
    beep_d = 1'b0;
    if (state_q == PED_WALK) beep_d = beep_q ^ tick;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) beep_q <= 1'b0;
    else          beep_q <= beep_d;
  end

  assign beep = (state_q == PED_WALK)  ? beep_q :
                (state_q == PED_FLASH) ? tick   : 1'b0;
`else
  assign beep = 1'b0;
`endif

  assign dbg.state       = state_q;
  assign dbg.sel         = sel_q;
  assign dbg.last_served = last_q;

endmodule

// File: tb/tb_crosswalk_scheduler.sv
// Bench for crosswalk_scheduler: directed scenarios with literal expectations plus
// a randomized phase, all checked every clk against a tick-counting behavioural model.
module tb_crosswalk_scheduler;
  import tl_pkg::*;

  localparam int DB = 4;
  localparam int WT = 10;
  localparam int FT = 6;
  localparam int HD = 8;
  localparam int P_IDLE = 0, P_REQ = 1, P_WALK = 2, P_FLASH = 3, P_HOLD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_0 = 1'b0, btn_1 = 1'b0;
  logic phase_grn_0 = 1'b0, phase_grn_1 = 1'b0;
  logic req_0, req_1, walk_0, dontwalk_0, walk_1, dontwalk_1, beep, tick;
  logic [1:0] pending;
  ped_dbg_t dbg;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  crosswalk_scheduler #(
    .TICK_DIV(2), .DEBOUNCE_TICKS(DB), .WALK_TON(WT),
    .FLASH_TON(FT), .HOLDOFF(HD), .TIMER_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_0(btn_0), .btn_1(btn_1),
    .phase_grn_0(phase_grn_0), .phase_grn_1(phase_grn_1),
    .req_0(req_0), .req_1(req_1), .walk_0(walk_0), .dontwalk_0(dontwalk_0),
    .walk_1(walk_1), .dontwalk_1(dontwalk_1), .pending(pending),
    .beep(beep), .tick(tick), .dbg(dbg)
  );

  // Reference model: phases with remaining-tick countdowns.
  typedef struct {
    int divc;
    bit [1:0] s1;
    bit [1:0] s2;
    int db0;
    int db1;
    bit [1:0] pend;
    int ph;
    int road;
    int last;
    int left;
    bit dw;
    bit bp;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.divc = 0; r.s1 = 0; r.s2 = 0; r.db0 = 0; r.db1 = 0; r.pend = 0;
    r.ph = P_IDLE; r.road = 0; r.last = 1; r.left = 0; r.dw = 0; r.bp = 0;
    return r;
  endfunction

  function automatic model_t step(model_t c, bit [1:0] b, bit [1:0] g);
    model_t n = c;
    bit t = (c.divc == 3);
    bit [1:0] set = 2'b00;
    bit [1:0] clr = 2'b00;
    int db[2];
    n.divc = (c.divc + 1) % 4;
    n.s1 = b;
    n.s2 = c.s1;
    db[0] = c.db0;
    db[1] = c.db1;
    for (int i = 0; i < 2; i++) begin
      if (!c.s2[i]) db[i] = 0;
      else if (t && db[i] < DB) begin
        db[i] = db[i] + 1;
        if (db[i] == DB) set[i] = 1'b1;
      end
    end
    n.db0 = db[0];
    n.db1 = db[1];
    case (c.ph)
      P_IDLE: if (c.pend != 2'b00) begin
        if (c.pend == 2'b01) n.road = 0;
        else if (c.pend == 2'b10) n.road = 1;
        else if (g[0] != g[1]) n.road = g[1] ? 1 : 0;
        else n.road = 1 - c.last;
        n.ph = P_REQ;
      end
      P_REQ: if (g[c.road]) begin
        clr[c.road] = 1'b1;
        n.last = c.road;
        n.ph = P_WALK;
        n.left = WT;
        n.bp = 1'b0;
      end
      P_WALK: begin
        if (!g[c.road]) begin
          n.ph = P_FLASH; n.left = FT; n.dw = 1'b0;
        end else if (t) begin
          n.bp = !c.bp;
          n.left = c.left - 1;
          if (n.left == 0) begin n.ph = P_FLASH; n.left = FT; n.dw = 1'b0; end
        end
      end
      P_FLASH: if (t) begin
        n.dw = !c.dw;
        n.left = c.left - 1;
        if (n.left == 0) begin n.ph = P_HOLD; n.left = HD; end
      end
      default: if (t) begin
        n.left = c.left - 1;
        if (n.left == 0) n.ph = P_IDLE;
      end
    endcase
    n.pend = (c.pend & ~clr) | set;
    return n;
  endfunction

  // Expected {req[1:0], walk[1:0], dontwalk[1:0], pending[1:0], beep, tick}
  function automatic logic [9:0] expv(model_t c);
    logic [1:0] rq = 2'b00;
    logic [1:0] wk = 2'b00;
    logic [1:0] dw = 2'b11;
    logic bp = 1'b0;
    logic tk = (c.divc == 3);
    if (c.ph == P_REQ || c.ph == P_WALK) rq[c.road] = 1'b1;
    if (c.ph == P_WALK) begin wk[c.road] = 1'b1; dw[c.road] = 1'b0; end
    if (c.ph == P_FLASH) dw[c.road] = c.dw;
`ifdef CROSSWALK_AUDIO_EN
    if (c.ph == P_WALK) bp = c.bp;
    else if (c.ph == P_FLASH) bp = tk;
`endif
    return {rq, wk, dw, c.pend, bp, tk};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= step(m, {btn_1, btn_0}, {phase_grn_1, phase_grn_0});
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int k = 0;
    while (seen < n && k < 8 * n + 16) begin
      @(negedge clk);
      k++;
      if (tick) seen++;
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL tick_wait: saw %0d ticks, wanted %0d", seen, n);
    end
  endtask

  task automatic wait_state(input ped_state_e s, input int budget, input string name);
    int k = 0;
    while (dbg.state != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (dbg.state != s) begin
      errors++;
      $display("FAIL %s: state=%0d after %0d clks, expected %0d", name, dbg.state, k, s);
    end
  endtask

  task automatic wait_pend(input logic [1:0] want, input int budget, input string name);
    int k = 0;
    while (pending != want && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (pending != want) begin
      errors++;
      $display("FAIL %s: pending=%b after %0d clks, expected %b", name, pending, k, want);
    end
  endtask

  // Counts tick pulses while the DUT stays in state s.
  task automatic count_ticks_in(input ped_state_e s, output int n);
    int k = 0;
    n = 0;
    while (dbg.state == s && k < 400) begin
      if (tick) n++;
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    int n;
    int hold0, hold1;
    logic [9:0] dv;

    fork
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          dv = {req_1, req_0, walk_1, walk_0, dontwalk_1, dontwalk_0, pending, beep, tick};
          checks++;
          if (dv !== expv(m)) begin
            errors++;
            if (errors <= 20)
              $display("FAIL model_cmp at %0t: got=%b expected=%b (req,walk,dw,pend,beep,tick)",
                       $time, dv, expv(m));
          end
        end
      end
    join_none

    // Reset state and prescaler start
    clk_n(3);
    cmp_en = 1'b1;
    lit("reset_lamps", {req_1, req_0, walk_1, walk_0, dontwalk_1, dontwalk_0, pending},
        32'b00_00_11_00);
    @(negedge clk); #3 reset_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!tick && k < 10);
    // Counter 0,1,2,3: tick is high in the 4th clk period after release
    lit("first_tick_clk", k, 3);

    // Tie with both greens low: last_served resets to 1, so road 0 goes first
    btn_0 = 1'b1; btn_1 = 1'b1;
    wait_pend(2'b11, 80, "tie_low_pend");
    btn_0 = 1'b0; btn_1 = 1'b0;
    @(negedge clk);
    lit("tie_low_first", {req_1, req_0}, 2'b01);
    clk_n(3); phase_grn_0 = 1'b1;
    wait_state(PED_WALK, 10, "tie_low_walk0");
    wait_state(PED_FLASH, 200, "tie_low_flash0");
    phase_grn_0 = 1'b0;
    wait_state(PED_REQ, 300, "tie_low_req1");
    lit("tie_low_second", {req_1, req_0}, 2'b10);
    phase_grn_1 = 1'b1;
    wait_state(PED_FLASH, 200, "tie_low_flash1");
    phase_grn_1 = 1'b0;
    wait_state(PED_IDLE, 300, "tie_low_idle");

    // Bounce: 3 ticks high, 1 low, 3 high never registers
    btn_0 = 1'b1; wait_ticks(3);
    btn_0 = 1'b0; wait_ticks(1);
    btn_0 = 1'b1; wait_ticks(3);
    btn_0 = 1'b0; clk_n(3);
    lit("bounce_pend", pending, 0);
    btn_0 = 1'b1;
    wait_pend(2'b01, 40, "press_pend");
    lit("press_req_same_clk", req_0, 0);
    btn_0 = 1'b0;
    @(negedge clk);
    lit("press_req_next_clk", req_0, 1);

    // Normal service on road 0
    clk_n(10); phase_grn_0 = 1'b1;
    wait_state(PED_WALK, 4, "svc_walk");
    lit("svc_lamps", {walk_0, dontwalk_0, walk_1, dontwalk_1}, 4'b1001);
    count_ticks_in(PED_WALK, n);
    lit("svc_walk_ticks", n, WT);
    phase_grn_0 = 1'b0;
    count_ticks_in(PED_FLASH, n);
    lit("svc_flash_ticks", n, FT);
    count_ticks_in(PED_HOLD, n);
    lit("svc_hold_ticks", n, HD);
    lit("svc_back_idle", dbg.state, PED_IDLE);

    // Tie with phase_grn_1 high: road 1 first, then road 0
    phase_grn_1 = 1'b1;
    btn_0 = 1'b1; btn_1 = 1'b1;
    wait_pend(2'b11, 80, "tie_g1_pend");
    btn_0 = 1'b0; btn_1 = 1'b0;
    @(negedge clk);
    lit("tie_g1_first", {req_1, req_0}, 2'b10);
    wait_state(PED_FLASH, 200, "tie_g1_flash");
    phase_grn_1 = 1'b0;
    wait_state(PED_REQ, 300, "tie_g1_req0");
    lit("tie_g1_second", {req_1, req_0}, 2'b01);
    phase_grn_0 = 1'b1;
    wait_state(PED_WALK, 4, "early_walk");

    // Early end: green drops after the 3rd WALK tick
    wait_ticks(3);
    phase_grn_0 = 1'b0;
    @(negedge clk);
    lit("early_flash", dbg.state, PED_FLASH);
    lit("early_req_walk", {req_0, walk_0}, 2'b00);
    wait_state(PED_IDLE, 300, "early_idle");

    // Asynchronous reset in the middle of WALK
    btn_1 = 1'b1;
    wait_pend(2'b10, 80, "rst_pend");
    btn_1 = 1'b0; phase_grn_1 = 1'b1;
    wait_state(PED_WALK, 10, "rst_walk");
    clk_n(5);
    #3 reset_n = 1'b0;
    #1 lit("rst_async", {walk_1, walk_0, dontwalk_1, dontwalk_0, req_1, req_0, pending},
           32'b00_11_00_00);
    clk_n(3); phase_grn_1 = 1'b0;
    #3 reset_n = 1'b1;

    // Randomized traffic with a loosely cooperating light controller
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (hold0 > 0) begin hold0--; if (hold0 == 0) btn_0 = 1'b0; end
      else if ($urandom_range(0, 60) == 0) begin btn_0 = 1'b1; hold0 = $urandom_range(3, 40); end
      if (hold1 > 0) begin hold1--; if (hold1 == 0) btn_1 = 1'b0; end
      else if ($urandom_range(0, 60) == 0) begin btn_1 = 1'b1; hold1 = $urandom_range(3, 40); end
      if (req_0 && !phase_grn_0 && $urandom_range(0, 5) == 0) begin phase_grn_0 = 1'b1; phase_grn_1 = 1'b0; end
      else if (req_1 && !phase_grn_1 && $urandom_range(0, 5) == 0) begin phase_grn_1 = 1'b1; phase_grn_0 = 1'b0; end
      else if (!req_0 && !req_1 && $urandom_range(0, 80) == 0) begin
        phase_grn_0 = $urandom_range(0, 1) == 1;
        phase_grn_1 = !phase_grn_0 && ($urandom_range(0, 1) == 1);
      end
      else if (phase_grn_0 && !req_0 && $urandom_range(0, 20) == 0) phase_grn_0 = 1'b0;
      else if (phase_grn_1 && !req_1 && $urandom_range(0, 20) == 0) phase_grn_1 = 1'b0;
      else if ($urandom_range(0, 150) == 0) begin phase_grn_0 = 1'b0; phase_grn_1 = 1'b0; end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
